// File: rtl/blake2_g_pipe.sv
// BLAKE2 mixing function G split into two registered half-rounds.
// One G result per cycle with valid/ready flow control on both sides and
// an opaque tag carried alongside so the round scheduler can match results.
module blake2_g_pipe #(
  parameter int unsigned W     = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  input  logic [W-1:0]     c_i,
  input  logic [W-1:0]     d_i,
  input  logic [W-1:0]     x_i,
  input  logic [W-1:0]     y_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [W-1:0]     a_o,
  output logic [W-1:0]     b_o,
  output logic [W-1:0]     c_o,
  output logic [W-1:0]     d_o,
  output logic [TAG_W-1:0] tag_o
);

  // BLAKE2s (W=32) and BLAKE2b (W=64) rotation constants.
  localparam int unsigned R1 = (W == 64) ? 32 : 16;
  localparam int unsigned R2 = (W == 64) ? 24 : 12;
  localparam int unsigned R3 = (W == 64) ? 16 : 8;
  localparam int unsigned R4 = (W == 64) ? 63 : 7;

  if (!(W == 32 || W == 64)) begin : g_bad_w
    $error("blake2_g_pipe: W must be 32 or 64");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("blake2_g_pipe: TAG_W must be at least 1");
  end

  function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input int unsigned r);
    return (v >> r) | (v << (W - r));
  endfunction

  // Stage 1 registers.
  logic             s1_valid_q;
  logic [W-1:0]     a1_q, b1_q, c1_q, d1_q, y1_q;
  logic [TAG_W-1:0] tag1_q;
  logic [W-1:0]     a1_d, b1_d, c1_d, d1_d;

  // Stage 2 registers, which drive the outputs directly.
  logic             s2_valid_q;
  logic [W-1:0]     a2_q, b2_q, c2_q, d2_q;
  logic [TAG_W-1:0] tag2_q;
  logic [W-1:0]     a2_d, b2_d, c2_d, d2_d;

  logic s1_ready, s2_ready;

  // Ready chain: a stage may load when empty or when its successor moves.
  always_comb begin
    s2_ready   = !s2_valid_q || out_ready_i;
    s1_ready   = !s1_valid_q || s2_ready;
    in_ready_o = s1_ready;
  end

  // First half-round from the input words.
  always_comb begin
    a1_d = a_i + b_i + x_i;
    d1_d = rotr(d_i ^ a1_d, R1);
    c1_d = c_i + d1_d;
    b1_d = rotr(b_i ^ c1_d, R2);
  end

  // Second half-round from the stage-1 registers.
  always_comb begin
    a2_d = a1_q + b1_q + y1_q;
    d2_d = rotr(d1_q ^ a2_d, R3);
    c2_d = c1_q + d2_d;
    b2_d = rotr(b1_q ^ c2_d, R4);
  end

  // Stage 1 register: data only captured with a valid beat.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s1_valid_q <= 1'b0;
      a1_q       <= '0;
      b1_q       <= '0;
      c1_q       <= '0;
      d1_q       <= '0;
      y1_q       <= '0;
      tag1_q     <= '0;
    end else if (s1_ready) begin
      s1_valid_q <= in_valid_i;
      if (in_valid_i) begin
        a1_q   <= a1_d;
        b1_q   <= b1_d;
        c1_q   <= c1_d;
        d1_q   <= d1_d;
        y1_q   <= y_i;
        tag1_q <= tag_i;
      end
    end
  end

  // Stage 2 register: holds everything while stalled by the consumer.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s2_valid_q <= 1'b0;
      a2_q       <= '0;
      b2_q       <= '0;
      c2_q       <= '0;
      d2_q       <= '0;
      tag2_q     <= '0;
    end else if (s2_ready) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        a2_q   <= a2_d;
        b2_q   <= b2_d;
        c2_q   <= c2_d;
        d2_q   <= d2_d;
        tag2_q <= tag1_q;
      end
    end
  end

  // Outputs come straight from stage-2 state.
  always_comb begin
    out_valid_o = s2_valid_q;
    a_o         = a2_q;
    b_o         = b2_q;
    c_o         = c2_q;
    d_o         = d2_q;
    tag_o       = tag2_q;
  end

endmodule

// File: tb/tb_blake2_g_pipe.sv
// Bench for blake2_g_pipe: a W=32 lane (0) and a W=64 lane (1) driven with
// random and directed beats, scored against a plain-arithmetic G model.
module tb_blake2_g_pipe;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    logic [63:0] d;
    logic [3:0]  tag;
  } res_t;

  logic clk;
  logic nreset;

  logic        in_valid [2];
  logic        out_ready[2];
  logic [63:0] a_in[2], b_in[2], c_in[2], d_in[2], x_in[2], y_in[2];
  logic [3:0]  tag_in[2];

  logic        ir32, ov32, ir64, ov64;
  logic [31:0] a_o32, b_o32, c_o32, d_o32;
  logic [63:0] a_o64, b_o64, c_o64, d_o64;
  logic [3:0]  tag_o32, tag_o64;

  int total;
  int bad;

  res_t q0[$];
  res_t q1[$];
  logic hold[2];
  res_t held[2];

  blake2_g_pipe #(.W(32), .TAG_W(4)) u_dut32 (
    .clk        (clk),
    .nreset     (nreset),
    .in_valid_i (in_valid[0]),
    .in_ready_o (ir32),
    .a_i        (a_in[0][31:0]),
    .b_i        (b_in[0][31:0]),
    .c_i        (c_in[0][31:0]),
    .d_i        (d_in[0][31:0]),
    .x_i        (x_in[0][31:0]),
    .y_i        (y_in[0][31:0]),
    .tag_i      (tag_in[0]),
    .out_valid_o(ov32),
    .out_ready_i(out_ready[0]),
    .a_o        (a_o32),
    .b_o        (b_o32),
    .c_o        (c_o32),
    .d_o        (d_o32),
    .tag_o      (tag_o32)
  );

  blake2_g_pipe #(.W(64), .TAG_W(4)) u_dut64 (
    .clk        (clk),
    .nreset     (nreset),
    .in_valid_i (in_valid[1]),
    .in_ready_o (ir64),
    .a_i        (a_in[1]),
    .b_i        (b_in[1]),
    .c_i        (c_in[1]),
    .d_i        (d_in[1]),
    .x_i        (x_in[1]),
    .y_i        (y_in[1]),
    .tag_i      (tag_in[1]),
    .out_valid_o(ov64),
    .out_ready_i(out_ready[1]),
    .a_o        (a_o64),
    .b_o        (b_o64),
    .c_o        (c_o64),
    .d_o        (d_o64),
    .tag_o      (tag_o64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [259:0] obs, input logic [259:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, obs, exp);
    end
  endtask

  function automatic logic [63:0] wmask(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] rot(input logic [63:0] v, input int r, input int w);
    return ((v >> r) | (v << (w - r))) & wmask(w);
  endfunction

  // Textbook G on w-bit words held in 64-bit variables.
  function automatic res_t g_ref(input int w, input logic [63:0] a, b, c, d, x, y,
                                 input logic [3:0] tag);
    res_t r;
    logic [63:0] m;
    int r1, r2, r3, r4;
    m  = wmask(w);
    r1 = (w == 64) ? 32 : 16;
    r2 = (w == 64) ? 24 : 12;
    r3 = (w == 64) ? 16 : 8;
    r4 = (w == 64) ? 63 : 7;
    a = (a + b + x) & m;
    d = rot(d ^ a, r1, w);
    c = (c + d) & m;
    b = rot(b ^ c, r2, w);
    a = (a + b + y) & m;
    d = rot(d ^ a, r3, w);
    c = (c + d) & m;
    b = rot(b ^ c, r4, w);
    r.a = a; r.b = b; r.c = c; r.d = d; r.tag = tag;
    return r;
  endfunction

  function automatic logic lane_ov(input int l);
    return (l == 1) ? ov64 : ov32;
  endfunction

  function automatic logic lane_ir(input int l);
    return (l == 1) ? ir64 : ir32;
  endfunction

  function automatic res_t lane_res(input int l);
    res_t r;
    if (l == 1) begin
      r.a = a_o64; r.b = b_o64; r.c = c_o64; r.d = d_o64; r.tag = tag_o64;
    end else begin
      r.a = {32'd0, a_o32}; r.b = {32'd0, b_o32};
      r.c = {32'd0, c_o32}; r.d = {32'd0, d_o32}; r.tag = tag_o32;
    end
    return r;
  endfunction

  function automatic res_t lane_exp(input int l);
    return g_ref((l == 1) ? 64 : 32, a_in[l], b_in[l], c_in[l], d_in[l], x_in[l], y_in[l],
                 tag_in[l]);
  endfunction

  // Scoreboard for one lane, evaluated mid-cycle when all signals are settled.
  task automatic mon_lane(input int l);
    res_t got;
    res_t e;
    got = lane_res(l);
    if (hold[l]) begin
      chk("hold_valid", lane_ov(l), 1'b1);
      chk("hold_data", got, held[l]);
    end
    hold[l] = lane_ov(l) && !out_ready[l];
    held[l] = got;
    if (lane_ov(l) && out_ready[l]) begin
      if ((l == 1) ? (q1.size() == 0) : (q0.size() == 0)) begin
        chk("spurious_out", 1'b1, 1'b0);
      end else begin
        e = (l == 1) ? q1.pop_front() : q0.pop_front();
        chk("result", got, e);
      end
    end
    if (in_valid[l] && lane_ir(l)) begin
      if (l == 1) q1.push_back(lane_exp(l));
      else        q0.push_back(lane_exp(l));
    end
  endtask

  always @(negedge clk) begin
    if (!nreset) begin
      q0.delete();
      q1.delete();
      hold[0] = 1'b0;
      hold[1] = 1'b0;
    end else begin
      mon_lane(0);
      mon_lane(1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int l, input logic v);
    logic [63:0] m;
    m = wmask((l == 1) ? 64 : 32);
    in_valid[l] = v;
    a_in[l] = {$urandom, $urandom} & m;
    b_in[l] = {$urandom, $urandom} & m;
    c_in[l] = {$urandom, $urandom} & m;
    d_in[l] = {$urandom, $urandom} & m;
    x_in[l] = {$urandom, $urandom} & m;
    y_in[l] = {$urandom, $urandom} & m;
    tag_in[l] = 4'($urandom);
  endtask

  task automatic drive_const(input int l, input logic [63:0] a, input logic [3:0] tag);
    in_valid[l] = 1'b1;
    a_in[l] = a; b_in[l] = '0; c_in[l] = '0; d_in[l] = '0; x_in[l] = '0; y_in[l] = '0;
    tag_in[l] = tag;
  endtask

  initial begin
    res_t k;
    total = 0;
    bad   = 0;
    nreset = 1'b0;
    for (int l = 0; l < 2; l++) begin
      in_valid[l] = 1'b0;
      out_ready[l] = 1'b1;
      a_in[l] = '0; b_in[l] = '0; c_in[l] = '0; d_in[l] = '0; x_in[l] = '0; y_in[l] = '0;
      tag_in[l] = '0;
      hold[l] = 1'b0;
    end

    // Reset state.
    #2;
    for (int l = 0; l < 2; l++) begin
      chk("rst_valid", lane_ov(l), 1'b0);
      chk("rst_ready", lane_ir(l), 1'b1);
      chk("rst_data", lane_res(l), '0);
    end
    step();
    step();
    nreset = 1'b1;
    step();

    // Directed vector: all zero, tag 3.
    drive_const(0, 64'd0, 4'd3);
    step();
    in_valid[0] = 1'b0;
    step();
    chk("zero_valid", lane_ov(0), 1'b1);
    k = '0;
    k.tag = 4'd3;
    chk("zero_vec", lane_res(0), k);

    // Directed vector: a=1, tag 5.
    drive_const(0, 64'd1, 4'd5);
    step();
    in_valid[0] = 1'b0;
    step();
    chk("one_valid", lane_ov(0), 1'b1);
    k.a = 64'h0000_0011;
    k.b = 64'h2022_0202;
    k.c = 64'h1101_0100;
    k.d = 64'h1100_0100;
    k.tag = 4'd5;
    chk("one_vec", lane_res(0), k);
    step();

    // Back-to-back streaming on both widths.
    for (int l = 0; l < 2; l++) begin
      out_ready[l] = 1'b1;
      for (int i = 0; i < 100; i++) begin
        drive(l, 1'b1);
        step();
        if (i >= 1) chk("stream_valid", lane_ov(l), 1'b1);
      end
      in_valid[l] = 1'b0;
      step();
      chk("stream_last", lane_ov(l), 1'b1);
      step();
      chk("stream_idle", lane_ov(l), 1'b0);
      chk("stream_drain", 260'(q0.size() + q1.size()), '0);
    end

    // Backpressure: capacity two, third beat waits, then drains in order.
    out_ready[0] = 1'b0;
    drive(0, 1'b1);
    step();
    drive(0, 1'b1);
    chk("bp_ready_1", lane_ir(0), 1'b1);
    step();
    drive(0, 1'b1);
    chk("bp_full", lane_ir(0), 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_stall_ready", lane_ir(0), 1'b0);
      chk("bp_stall_valid", lane_ov(0), 1'b1);
    end
    out_ready[0] = 1'b1;
    #1;
    chk("bp_release_ready", lane_ir(0), 1'b1);
    step();
    in_valid[0] = 1'b0;
    step();
    step();
    step();
    chk("bp_drain", 260'(q0.size()), '0);

    // Random valid/ready toggling on the 64-bit lane.
    for (int i = 0; i < 10000; i++) begin
      drive(1, $urandom_range(0, 3) != 0);
      out_ready[1] = $urandom_range(0, 2) != 0;
      step();
    end
    in_valid[1] = 1'b0;
    out_ready[1] = 1'b1;
    step();
    step();
    step();
    chk("rand_drain", 260'(q1.size()), '0);

    // Reset while both stages are full and stalled.
    out_ready[1] = 1'b0;
    drive(1, 1'b1);
    step();
    drive(1, 1'b1);
    step();
    in_valid[1] = 1'b0;
    chk("pre_rst_full", lane_ir(1), 1'b0);
    chk("pre_rst_valid", lane_ov(1), 1'b1);
    nreset = 1'b0;
    #1;
    chk("mid_rst_valid", lane_ov(1), 1'b0);
    chk("mid_rst_ready", lane_ir(1), 1'b1);
    chk("mid_rst_data", lane_res(1), '0);
    step();
    chk("mid_rst_ready_held", lane_ir(1), 1'b1);
    nreset = 1'b1;
    step();
    out_ready[1] = 1'b1;
    drive(1, 1'b1);
    k = lane_exp(1);
    step();
    in_valid[1] = 1'b0;
    step();
    chk("post_rst_valid", lane_ov(1), 1'b1);
    chk("post_rst_data", lane_res(1), k);
    step();
    step();
    chk("final_drain", 260'(q0.size() + q1.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
